// File: rtl/cheri_tsmap_arbiter.sv
// rtl/cheri_tsmap_arbiter.sv - single-port TSMAP SRAM arbiter: trvk lookups, software bus, bulk zero-fill
//
// Purpose
//   The TSMAP (temporal-safety revocation bitmap) lives in one single-port SRAM.
//   This block shares that SRAM between three requesters:
//   - the trvk lookup stage: read-only, fixed latency, never stalled;
//   - a software bus port: reads and byte-masked writes;
//   - a bulk-clear engine: zero-fills the whole map.
//   Priority, highest first: trvk, clear engine, bus. The SRAM sees at most one access per cycle.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   tsmap_cs_i/addr_i      trvk lookup request and word index
//   tsmap_rdata_o          lookup data, the cycle after tsmap_cs_i (0 when out of range)
//   bus_req_i/we_i/addr_i  software request: write enable and word index
//   bus_wdata_i/be_i       software write data and byte enables
//   bus_gnt_o              request accepted this cycle
//   bus_rvalid_o           response, the cycle after bus_gnt_o
//   bus_rdata_o            read data (0 for writes and errors)
//   bus_err_o              out-of-range address, qualifies bus_rvalid_o
//   clr_start_i            pulse: start the bulk zero-fill
//   clr_busy_o             clear engine active
//   clr_done_o             one-cycle pulse after the clear completes
//   mem_*                  SRAM interface; read data has 1-cycle latency
module cheri_tsmap_arbiter #(
  parameter int unsigned  TSMapSize = 1024,
  localparam int unsigned AW        = $clog2(TSMapSize)
) (
  input  logic          clk_i,
  input  logic          rst_ni,

  input  logic          tsmap_cs_i,
  input  logic [15:0]   tsmap_addr_i,
  output logic [31:0]   tsmap_rdata_o,

  input  logic          bus_req_i,
  input  logic          bus_we_i,
  input  logic [15:0]   bus_addr_i,
  input  logic [31:0]   bus_wdata_i,
  input  logic [3:0]    bus_be_i,
  output logic          bus_gnt_o,
  output logic          bus_rvalid_o,
  output logic [31:0]   bus_rdata_o,
  output logic          bus_err_o,

  input  logic          clr_start_i,
  output logic          clr_busy_o,
  output logic          clr_done_o,

  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic [3:0]    mem_be_o,
  input  logic [31:0]   mem_rdata_i
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam logic [AW-1:0] LastWord = AW'(TSMapSize - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // Two-stage done pipeline: the FSM is back in IDLE the cycle after the last
  // zero write, and the done pulse is reported one cycle later still.
  logic          clr_last;
  logic          last_q;
  logic          done_q;

  // Response qualifiers for data returning from the SRAM one cycle later.
  logic          trvk_hit_q;
  logic          bus_rvalid_q;
  logic          bus_err_q;
  logic          bus_rd_q;

  logic          trvk_in_range;
  logic          bus_in_range;
  logic          bus_gnt;

  assign trvk_in_range = 32'(tsmap_addr_i) < TSMapSize;
  assign bus_in_range  = 32'(bus_addr_i) < TSMapSize;

  // Any trvk request, even out of range, blocks the bus and stalls the clear:
  // the trvk slot is reserved whether or not it ends up touching the SRAM.
  assign bus_gnt = bus_req_i & ~tsmap_cs_i & (state_q == IDLE) & ~clr_start_i;

  // ---------------------------------------------------------------------------
  // Clear engine FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_start_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // A trvk cycle is a bubble; the counter only advances on a real write.
        if (!tsmap_cs_i) begin
          if (cnt_q == LastWord) begin
            state_d  = IDLE;
            cnt_d    = '0;
            clr_last = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= clr_last;
      done_q  <= last_q;
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM port mux
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (tsmap_cs_i) begin
      // Out-of-range trvk lookups still own the slot but issue nothing.
      if (trvk_in_range) begin
        mem_req_o  = 1'b1;
        mem_addr_o = tsmap_addr_i[AW-1:0];
      end
    end else if (state_q == CLEAR) begin
      mem_req_o  = 1'b1;
      mem_we_o   = 1'b1;
      mem_addr_o = cnt_q;
      mem_be_o   = 4'hF;
    end else if (bus_gnt && bus_in_range) begin
      mem_req_o   = 1'b1;
      mem_we_o    = bus_we_i;
      mem_addr_o  = bus_addr_i[AW-1:0];
      mem_wdata_o = bus_wdata_i;
      mem_be_o    = bus_be_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Response tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trvk_hit_q   <= 1'b0;
      bus_rvalid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      bus_rd_q     <= 1'b0;
    end else begin
      trvk_hit_q   <= tsmap_cs_i & trvk_in_range;
      bus_rvalid_q <= bus_gnt;
      bus_err_q    <= bus_gnt & ~bus_in_range;
      bus_rd_q     <= bus_gnt & bus_in_range & ~bus_we_i;
    end
  end

  // Gating with the hit flag gives 0 for out-of-range lookups and after reset.
  assign tsmap_rdata_o = trvk_hit_q ? mem_rdata_i : 32'h0;
  assign bus_rdata_o   = bus_rd_q ? mem_rdata_i : 32'h0;
  assign bus_gnt_o     = bus_gnt;
  assign bus_rvalid_o  = bus_rvalid_q;
  assign bus_err_o     = bus_err_q;
  assign clr_busy_o    = (state_q == CLEAR);
  assign clr_done_o    = done_q;

endmodule
